seg_status_decoder: RTL and testbench
=====================================

SEG_STATUS_DECODER -- requirements
Module: seg_status_decoder

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter STABLE_CYCLES, default 4, range 2..15, SHALL set the consecutive synchronized cycles required to accept a segment pattern.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of each event counter.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 SEG  input  7  SHALL be the asynchronous active-high segment lines {G,F,E,D,C,B,A}.
REQ-007 OUT_READY  input  1  SHALL be the consumer ready for the status event.
REQ-008 OUT_VALID  output  1  SHALL flag that a decoded status event is pending.
REQ-009 STATUS_AC, STATUS_CO, STATUS_RE  output  1 each  SHALL be the one-hot decoded status; they are valid only while OUT_VALID=1.
REQ-010 PAT_ERR  output  1  SHALL be a one-cycle pulse when a stable pattern is unrecognized.
REQ-011 OVERFLOW  output  1  SHALL be a sticky flag set when an event is dropped; it is cleared only by reset.
REQ-012 CNT_AC, CNT_CO, CNT_RE  output  CNT_W each  SHALL be saturating event counters.

Function
REQ-013 SEG SHALL pass through a 2-flop synchronizer; all decoding SHALL use the second stage (SEG_S).
REQ-014 Pattern classes SHALL be: AC=7'h77, CO=7'h39, RE=7'h33, BLANK=7'h00; any other value is UNKNOWN.
REQ-015 The FSM SHALL have three states: IDLE, FILTER and LOCKED, plus a 4-bit stable counter STC and a 7-bit register LOCK_PAT.
REQ-016 IDLE: if SEG_S differs from 7'h00 -> FILTER with STC=1; otherwise remain in IDLE.
REQ-017 FILTER: if SEG_S differs from its value on the previous cycle -> STC=1 and remain in FILTER; if it is equal, STC SHALL increment.
REQ-018 FILTER: when STC reaches STABLE_CYCLES, the FSM SHALL move to LOCKED, set LOCK_PAT=SEG_S and classify the pattern in that same cycle.
REQ-019 Classification AC/CO/RE SHALL generate an event; BLANK SHALL go to IDLE with no event; UNKNOWN SHALL pulse PAT_ERR for 1 cycle and move to LOCKED with no event.
REQ-020 LOCKED: if SEG_S differs from LOCK_PAT -> FILTER with STC=1; otherwise remain in LOCKED, so a held pattern reports only once.
REQ-021 Latency: with a prior stable pattern different from P, OUT_VALID SHALL rise exactly 2+STABLE_CYCLES rising edges after the first edge that samples P on SEG.
REQ-022 An event SHALL load the one-hot STATUS_* outputs, set OUT_VALID=1 and increment the matching CNT_* by 1.
REQ-023 CNT_* SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 OUT_VALID and STATUS_* SHALL stay stable until a cycle in which OUT_VALID=1 and OUT_READY=1; OUT_VALID then clears on the next edge.
REQ-025 An event arriving while OUT_VALID=1 and OUT_READY=0 SHALL be dropped: STATUS_* unchanged, OVERFLOW=1, and the counter still increments.
REQ-026 An event arriving in the same cycle as the handshake (OUT_VALID=1 and OUT_READY=1) SHALL load the new status with OUT_VALID kept at 1 and no overflow.
REQ-027 At most one STATUS_* bit SHALL be 1 at any time, and all STATUS_* bits SHALL be 0 whenever OUT_VALID=0.

Reset
REQ-028 RST_N=0 SHALL immediately force: FSM=IDLE, STC=0, LOCK_PAT=0, synchronizer=0, OUT_VALID=0, STATUS_*=0, PAT_ERR=0, OVERFLOW=0, CNT_*=0.
REQ-029 Reset asserted mid-filter or with an event pending SHALL discard that state with no event or error after release.
REQ-030 After RST_N rises, the first SEG sample SHALL occur on the next rising edge.

Verification
REQ-031 Scenario: SEG=7'h77 held for 20 cycles, OUT_READY=1 -> OUT_VALID rises at edge 6 with STATUS_AC=1, exactly one event, CNT_AC=1.
REQ-032 Scenario: SEG toggles between 7'h39 and 7'h00 every 3 cycles with STABLE_CYCLES=4 -> no event, no PAT_ERR, all counters remain 0.
REQ-033 Scenario: 7'h33, then 7'h77, each stable for 10 cycles, OUT_READY=0 -> STATUS_RE held, OVERFLOW=1, CNT_RE=1, CNT_AC=1.
REQ-034 Scenario: SEG=7'h7F stable -> a single PAT_ERR pulse, OUT_VALID stays 0, counters unchanged.
REQ-035 Scenario: pulse OUT_READY in the same cycle a new CO event is generated -> STATUS_CO loaded, OUT_VALID remains 1, OVERFLOW=0.
REQ-036 Scenario: 300 AC events separated by BLANK with CNT_W=8, then RST_N pulsed low for 1 cycle in the middle of a filter window -> CNT_AC=255 before the reset; after it, all outputs are 0 and no spurious event occurs.

Source files
------------

// File: rtl/seg_status_decoder.sv
// Seven-segment status decoder. Debounces a synchronized segment pattern,
// classifies it as AC/CO/RE and hands it to a consumer through a valid/ready flag.
module seg_status_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_seg,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic             o_status_ac,
    output logic             o_status_co,
    output logic             o_status_re,
    output logic             o_pat_err,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_cnt_ac,
    output logic [CNT_W-1:0] o_cnt_co,
    output logic [CNT_W-1:0] o_cnt_re
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILTER = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [6:0] PAT_AC    = 7'h77;
    localparam logic [6:0] PAT_CO    = 7'h39;
    localparam logic [6:0] PAT_RE    = 7'h33;
    localparam logic [6:0] PAT_BLANK = 7'h00;

    localparam logic [3:0]       STABLE_LIM = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [6:0]       r_sync1;
    logic [6:0]       r_seg_s;
    logic [6:0]       r_seg_prev;
    logic [1:0]       r_state;
    logic [3:0]       r_stc;
    logic [6:0]       r_lock_pat;
    logic             r_valid;
    logic [2:0]       r_status;
    logic             r_pat_err;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt_ac;
    logic [CNT_W-1:0] r_cnt_co;
    logic [CNT_W-1:0] r_cnt_re;

    logic [1:0] w_state_nxt;
    logic [3:0] w_stc_nxt;
    logic [3:0] w_stc_inc;
    logic [6:0] w_lock_nxt;
    logic       w_event;
    logic [2:0] w_event_cls;
    logic       w_err;

    assign w_stc_inc = r_stc + 4'd1;

    // The pattern is classified in the same cycle the stable count completes,
    // so the event reaches the output register one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_stc_nxt   = r_stc;
        w_lock_nxt  = r_lock_pat;
        w_event     = 1'b0;
        w_event_cls = 3'b000;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_seg_s != PAT_BLANK) begin
                    w_state_nxt = S_FILTER;
                    w_stc_nxt   = 4'd1;
                end
            end
            S_FILTER: begin
                if (r_seg_s != r_seg_prev) begin
                    w_stc_nxt = 4'd1;
                end else if (w_stc_inc == STABLE_LIM) begin
                    w_stc_nxt  = w_stc_inc;
                    w_lock_nxt = r_seg_s;
                    case (r_seg_s)
                        PAT_AC: begin
                            w_state_nxt = S_LOCKED;
                            w_event     = 1'b1;
                            w_event_cls = 3'b100;
                        end
                        PAT_CO: begin
                            w_state_nxt = S_LOCKED;
                            w_event     = 1'b1;
                            w_event_cls = 3'b010;
                        end
                        PAT_RE: begin
                            w_state_nxt = S_LOCKED;
                            w_event     = 1'b1;
                            w_event_cls = 3'b001;
                        end
                        PAT_BLANK: begin
                            w_state_nxt = S_IDLE;
                        end
                        default: begin
                            w_state_nxt = S_LOCKED;
                            w_err       = 1'b1;
                        end
                    endcase
                end else begin
                    w_stc_nxt = w_stc_inc;
                end
            end
            S_LOCKED: begin
                if (r_seg_s != r_lock_pat) begin
                    w_state_nxt = S_FILTER;
                    w_stc_nxt   = 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stc_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 7'h00;
            r_seg_s    <= 7'h00;
            r_seg_prev <= 7'h00;
            r_state    <= S_IDLE;
            r_stc      <= 4'd0;
            r_lock_pat <= 7'h00;
            r_pat_err  <= 1'b0;
        end else begin
            r_sync1    <= i_seg;
            r_seg_s    <= r_sync1;
            r_seg_prev <= r_seg_s;
            r_state    <= w_state_nxt;
            r_stc      <= w_stc_nxt;
            r_lock_pat <= w_lock_nxt;
            r_pat_err  <= w_err;
        end
    end

    // A new event is only dropped when the previous one is still unacknowledged;
    // counters record every event regardless.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_status   <= 3'b000;
            r_overflow <= 1'b0;
            r_cnt_ac   <= '0;
            r_cnt_co   <= '0;
            r_cnt_re   <= '0;
        end else begin
            if (w_event) begin
                if (r_valid && !i_out_ready) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_valid  <= 1'b1;
                    r_status <= w_event_cls;
                end
            end else if (r_valid && i_out_ready) begin
                r_valid  <= 1'b0;
                r_status <= 3'b000;
            end
            if (w_event_cls[2] && (r_cnt_ac != CNT_MAX)) r_cnt_ac <= r_cnt_ac + CNT_ONE;
            if (w_event_cls[1] && (r_cnt_co != CNT_MAX)) r_cnt_co <= r_cnt_co + CNT_ONE;
            if (w_event_cls[0] && (r_cnt_re != CNT_MAX)) r_cnt_re <= r_cnt_re + CNT_ONE;
        end
    end

    assign o_out_valid = r_valid;
    assign o_status_ac = r_status[2];
    assign o_status_co = r_status[1];
    assign o_status_re = r_status[0];
    assign o_pat_err   = r_pat_err;
    assign o_overflow  = r_overflow;
    assign o_cnt_ac    = r_cnt_ac;
    assign o_cnt_co    = r_cnt_co;
    assign o_cnt_re    = r_cnt_re;

endmodule

// File: tb/tb_seg_status_decoder.sv
// Bench for seg_status_decoder: directed scenarios plus random segment streams
// compared cycle by cycle against a run-length reference model.
module tb_seg_status_decoder;

    localparam int STABLE = 4;
    localparam int CW     = 8;

    logic          clk   = 1'b0;
    logic          rstN  = 1'b1;
    logic [6:0]    seg   = 7'h00;
    logic          ready = 1'b0;
    logic          outValid, statusAc, statusCo, statusRe, patErr, overflow;
    logic [CW-1:0] cntAc, cntCo, cntRe;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    seg_status_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_seg       (seg),
        .i_out_ready (ready),
        .o_out_valid (outValid),
        .o_status_ac (statusAc),
        .o_status_co (statusCo),
        .o_status_re (statusRe),
        .o_pat_err   (patErr),
        .o_overflow  (overflow),
        .o_cnt_ac    (cntAc),
        .o_cnt_co    (cntCo),
        .o_cnt_re    (cntRe)
    );

    // Reference model: the synchronized stream is the input delayed two samples;
    // once the stream departs from the accepted pattern, the first run of STABLE
    // identical samples becomes the newly accepted pattern.
    logic [6:0] segPipe[$];
    logic [6:0] mAccepted, mPrev, mS;
    bit         mHunting, mValid, mPerr, mOvf, mEv, mErr;
    int         mRun, mCntAc, mCntCo, mCntRe;
    logic [2:0] mStatus, mCls;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            segPipe.delete();
            segPipe.push_back(7'h00);
            segPipe.push_back(7'h00);
            mAccepted = 7'h00; mPrev = 7'h00; mHunting = 0; mRun = 0;
            mValid = 0; mStatus = 3'b000; mPerr = 0; mOvf = 0;
            mCntAc = 0; mCntCo = 0; mCntRe = 0;
        end else if (segPipe.size() == 2) begin
            mS = segPipe.pop_front();
            segPipe.push_back(seg);
            mEv = 0; mErr = 0; mCls = 3'b000;
            if (!mHunting) begin
                if (mS != mAccepted) begin
                    mHunting = 1;
                    mRun     = 1;
                end
            end else begin
                mRun = (mS == mPrev) ? mRun + 1 : 1;
                if (mRun == STABLE) begin
                    mHunting  = 0;
                    mAccepted = mS;
                    if      (mS == 7'h77) begin mEv = 1; mCls = 3'b100; end
                    else if (mS == 7'h39) begin mEv = 1; mCls = 3'b010; end
                    else if (mS == 7'h33) begin mEv = 1; mCls = 3'b001; end
                    else if (mS != 7'h00) mErr = 1;
                end
            end
            mPrev = mS;
            mPerr = mErr;
            if (mEv) begin
                if (mCls[2] && mCntAc < 255) mCntAc++;
                if (mCls[1] && mCntCo < 255) mCntCo++;
                if (mCls[0] && mCntRe < 255) mCntRe++;
                if (mValid && !ready) mOvf = 1;
                else begin mValid = 1; mStatus = mCls; end
            end else if (mValid && ready) begin
                mValid  = 0;
                mStatus = 3'b000;
            end
        end
    end

    logic [29:0] dutVec, modelVec;
    assign dutVec   = {outValid, statusAc, statusCo, statusRe, patErr, overflow, cntAc, cntCo, cntRe};
    assign modelVec = {mValid, mStatus, mPerr, mOvf, CW'(mCntAc), CW'(mCntCo), CW'(mCntRe)};

    task automatic resetDut();
        @(negedge clk);
        rstN  = 1'b0;
        seg   = 7'h00;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        seg   = 7'h77;
        ready = 1'b1;
        rstN  = 1'b0;
        #2;
        checks++;
        if (dutVec !== 30'h0) begin
            fails++;
            $display("[TB] FAIL reset_immediate: got %h expected %h", dutVec, 30'h0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dutVec !== 30'h0) begin
            fails++;
            $display("[TB] FAIL reset_held: got %h expected %h", dutVec, 30'h0);
        end
        seg  = 7'h00;
        rstN = 1'b1;
    endtask

    task automatic test_ac_latency();
        int riseEdge = 0;
        int rises = 0;
        bit prevValid = 0;
        logic [2:0] statusAtRise = 3'b000;
        resetDut();
        ready = 1'b1;
        repeat (4) @(negedge clk);
        seg = 7'h77;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== modelVec) begin
                fails++;
                $display("[TB] FAIL ac_track edge %0d: got %h expected %h", k, dutVec, modelVec);
            end
            if (outValid && !prevValid) begin
                rises++;
                if (riseEdge == 0) begin
                    riseEdge = k;
                    statusAtRise = {statusAc, statusCo, statusRe};
                end
            end
            prevValid = outValid;
        end
        checks++;
        if (riseEdge != 2 + STABLE) begin
            fails++;
            $display("[TB] FAIL ac_latency: got %0d expected %0d", riseEdge, 2 + STABLE);
        end
        checks++;
        if (rises != 1) begin
            fails++;
            $display("[TB] FAIL ac_event_count: got %0d expected 1", rises);
        end
        checks++;
        if (statusAtRise !== 3'b100) begin
            fails++;
            $display("[TB] FAIL ac_status: got %b expected 100", statusAtRise);
        end
        checks++;
        if (cntAc !== 8'd1) begin
            fails++;
            $display("[TB] FAIL ac_count: got %0d expected 1", cntAc);
        end
    endtask

    task automatic test_glitch_filter();
        bit sawValid = 0;
        bit sawErr = 0;
        resetDut();
        ready = 1'b1;
        for (int k = 0; k < 36; k++) begin
            seg = (((k / 3) % 2) == 0) ? 7'h39 : 7'h00;
            @(negedge clk);
            checks++;
            if (dutVec !== modelVec) begin
                fails++;
                $display("[TB] FAIL glitch_track cycle %0d: got %h expected %h", k, dutVec, modelVec);
            end
            sawValid |= outValid;
            sawErr   |= patErr;
        end
        checks++;
        if (sawValid || sawErr) begin
            fails++;
            $display("[TB] FAIL glitch_no_event: got valid=%0d err=%0d expected 0 0", sawValid, sawErr);
        end
        checks++;
        if ({cntAc, cntCo, cntRe} !== 24'h0) begin
            fails++;
            $display("[TB] FAIL glitch_counters: got %h expected 0", {cntAc, cntCo, cntRe});
        end
    endtask

    task automatic test_overflow();
        resetDut();
        ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seg = (k < 10) ? 7'h33 : 7'h77;
            @(negedge clk);
            checks++;
            if (dutVec !== modelVec) begin
                fails++;
                $display("[TB] FAIL ovf_track cycle %0d: got %h expected %h", k, dutVec, modelVec);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({outValid, statusAc, statusCo, statusRe, overflow} !== 5'b10011) begin
            fails++;
            $display("[TB] FAIL ovf_status: got %b expected 10011",
                     {outValid, statusAc, statusCo, statusRe, overflow});
        end
        checks++;
        if ({cntAc, cntCo, cntRe} !== {8'd1, 8'd0, 8'd1}) begin
            fails++;
            $display("[TB] FAIL ovf_counters: got %h expected 010001", {cntAc, cntCo, cntRe});
        end
    endtask

    task automatic test_unknown();
        int errCycles = 0;
        bit sawValid = 0;
        resetDut();
        ready = 1'b1;
        seg   = 7'h7F;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== modelVec) begin
                fails++;
                $display("[TB] FAIL unk_track cycle %0d: got %h expected %h", k, dutVec, modelVec);
            end
            if (patErr) errCycles++;
            sawValid |= outValid;
        end
        checks++;
        if (errCycles != 1 || sawValid) begin
            fails++;
            $display("[TB] FAIL unk_pulse: got err=%0d valid=%0d expected 1 0", errCycles, sawValid);
        end
        checks++;
        if ({cntAc, cntCo, cntRe} !== 24'h0) begin
            fails++;
            $display("[TB] FAIL unk_counters: got %h expected 0", {cntAc, cntCo, cntRe});
        end
    endtask

    task automatic test_back_to_back();
        resetDut();
        ready = 1'b0;
        seg   = 7'h77;
        repeat (10) @(negedge clk);
        seg = 7'h39;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== modelVec) begin
                fails++;
                $display("[TB] FAIL b2b_track edge %0d: got %h expected %h", k, dutVec, modelVec);
            end
            if (k == 6) begin
                checks++;
                if ({outValid, statusAc, statusCo, statusRe, overflow} !== 5'b10100) begin
                    fails++;
                    $display("[TB] FAIL b2b_load: got %b expected 10100",
                             {outValid, statusAc, statusCo, statusRe, overflow});
                end
                ready = 1'b0;
            end
            if (k == 5) ready = 1'b1;
        end
    endtask

    task automatic test_random();
        logic [6:0] table7 [6] = '{7'h77, 7'h39, 7'h33, 7'h00, 7'h7F, 7'h00};
        int hold;
        resetDut();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) seg = 7'($urandom_range(0, 127));
            else seg = table7[$urandom_range(0, 5)];
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                checks++;
                if (dutVec !== modelVec) begin
                    fails++;
                    $display("[TB] FAIL rand_track seg %0d: got %h expected %h", n, dutVec, modelVec);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit sawValid = 0;
        bit sawErr = 0;
        resetDut();
        ready = 1'b1;
        for (int e = 0; e < 300; e++) begin
            for (int k = 0; k < 12; k++) begin
                seg = (k < 6) ? 7'h77 : 7'h00;
                @(negedge clk);
                checks++;
                if (dutVec !== modelVec) begin
                    fails++;
                    $display("[TB] FAIL sat_track event %0d: got %h expected %h", e, dutVec, modelVec);
                end
            end
        end
        checks++;
        if (cntAc !== 8'd255) begin
            fails++;
            $display("[TB] FAIL sat_count: got %0d expected 255", cntAc);
        end
        seg = 7'h77;
        repeat (3) @(negedge clk);
        rstN = 1'b0;
        seg  = 7'h00;
        #1;
        checks++;
        if (dutVec !== 30'h0) begin
            fails++;
            $display("[TB] FAIL sat_reset: got %h expected 0", dutVec);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== modelVec) begin
                fails++;
                $display("[TB] FAIL post_reset_track cycle %0d: got %h expected %h", k, dutVec, modelVec);
            end
            sawValid |= outValid;
            sawErr   |= patErr;
        end
        checks++;
        if (sawValid || sawErr || dutVec !== 30'h0) begin
            fails++;
            $display("[TB] FAIL post_reset_quiet: got %h valid=%0d err=%0d expected 0", dutVec, sawValid, sawErr);
        end
    endtask

    initial begin
        $display("[TB] starting seg_status_decoder bench");
        test_reset();
        test_ac_latency();
        test_glitch_filter();
        test_overflow();
        test_unknown();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
